ex_muldiv_unit: RTL and testbench
=================================

# ex_muldiv_unit

Iterative 32-bit multiply/divide unit for the EX stage, fed directly by the ID/EX pipeline register outputs (RD1out/RD2out as operands, decoded ALUop as start/op). It computes MULT, MULTU, DIV and DIVU into architectural HI/LO registers over multiple cycles and raises Busy so hazard logic stalls IF/ID/ID-EX. It also services MTHI/MTLO writes and supplies HI/LO to the MFHI/MFLO path.

## Interface
- No parameters; data width fixed at 32.
- Clk  in  1  pipeline clock; all state updates on rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- Start  in  1  request a new operation; sampled only when Busy=0.
- Op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with Start.
- A  in  32  operand rs (multiplicand / dividend).
- B  in  32  operand rt (multiplier / divisor).
- Flush  in  1  abort in-flight operation (branch/exception squash).
- HiWe  in  1  MTHI write enable.
- LoWe  in  1  MTLO write enable.
- WData  in  32  MTHI/MTLO data.
- Busy  out  1  operation in progress; hazard unit stalls on it.
- Done  out  1  one-cycle pulse: HI/LO updated by a completed operation.
- DivByZero  out  1  one-cycle pulse coincident with Done when a DIV/DIVU had B=0.
- Hi  out  32  HI register.
- Lo  out  32  LO register.

## Operation
- States: IDLE, CALC. Reset: state IDLE, Hi=0, Lo=0, Busy=0, Done=0, DivByZero=0, iteration count 0.
- IDLE, Start=1, Flush=0: latch Op, sign flags of A/B (signed ops only), magnitudes |A|, |B| (unsigned ops: raw values); count=0; go CALC.
- CALC: one iteration per cycle, 32 iterations. Multiply: shift-add on 64-bit accumulator. Divide: restoring shift-subtract, 33-bit partial remainder.
- After 32nd iteration: apply sign fix, write Hi/Lo, pulse Done, return IDLE.
- Sign rules: product negated if sign(A)!=sign(B); quotient negated if signs differ; remainder takes sign of dividend. Results truncated to 32 bits each (wrap).
- MULT/MULTU: Hi=product[63:32], Lo=product[31:0]. DIV/DIVU: Lo=quotient, Hi=remainder.
- DIV of 0x80000000 by 0xFFFFFFFF: Lo=0x80000000, Hi=0 (natural wrap, no flag).
- B=0 on DIV/DIVU: normal latency; Lo=0xFFFFFFFF, Hi=A (as input); DivByZero pulses with Done.
- Flush in CALC: return IDLE next edge; Hi/Lo unchanged; no Done. Flush in IDLE suppresses Start that cycle.
- Start while Busy=1: ignored (no queueing).
- HiWe/LoWe: honored only in IDLE with Start=0; both may assert together. Ignored while Busy or when Start accepted (Start wins).

## Timing
- Start accepted at edge E0; Busy=1 from E0 until E33; iterations on E1..E32; Hi/Lo, Done, DivByZero update at E33 and Busy falls at E33. Latency 33 cycles Start-edge to result.
- Done/DivByZero high exactly one cycle after E33.
- Back-to-back: Start may be accepted at E34 edge (cycle where Done=1); no idle gap required.
- HiWe/LoWe: Hi/Lo updated at the same edge write is sampled; visible next cycle.
- Hi/Lo outputs registered; never change mid-operation.
- Rst_n low at any time (incl. mid-CALC): immediate return to reset values, no Done.

## Test plan
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> after 33 cycles Hi=0xFFFFFFFE, Lo=0x00000001, Done one cycle, Busy high exactly 33 cycles.
- MULT A=-7 (0xFFFFFFF9), B=6 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFD6; then DIV A=-7, B=2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1).
- DIVU A=100, B=0 -> Lo=0xFFFFFFFF, Hi=100, DivByZero and Done pulse together; DIV 0x80000000/0xFFFFFFFF -> Lo=0x80000000, Hi=0, no flag.
- Start DIVU, assert Flush at cycle 10 -> Busy low next edge, Hi/Lo keep prior values, no Done; Start during Busy ignored (result matches first operands only).
- MTHI WData=0x12345678 in IDLE -> Hi=0x12345678 next cycle; HiWe with Start same cycle -> write dropped, op runs; HiWe while Busy -> dropped.
- Rst_n low mid-CALC at cycle 20 -> all outputs zero asynchronously; after release, new MULTU 3x5 -> Lo=15, Hi=0 at 33 cycles; back-to-back Start on Done cycle accepted.

Source files
------------

// File: rtl/ex_muldiv_unit_if.sv
// Handshake/data bundle between the EX-stage control and the iterative mul/div unit.
// The master side drives requests and MTHI/MTLO writes; the slave side returns status and HI/LO.
interface ex_muldiv_unit_if;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Flush;
    logic        HiWe;
    logic        LoWe;
    logic [31:0] WData;
    logic        Busy;
    logic        Done;
    logic        DivByZero;
    logic [31:0] Hi;
    logic [31:0] Lo;

    modport master (
        output Start, Op, A, B, Flush, HiWe, LoWe, WData,
        input  Busy, Done, DivByZero, Hi, Lo
    );

    modport slave (
        input  Start, Op, A, B, Flush, HiWe, LoWe, WData,
        output Busy, Done, DivByZero, Hi, Lo
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative 32x32 multiply / 32/32 divide producing architectural HI/LO.
// Operates on magnitudes over 32 iterations and applies the sign correction on the final cycle.
module ex_muldiv_unit (
    input  logic                  Clk,
    input  logic                  Rst_n,
    ex_muldiv_unit_if.slave       bus
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_CALC = 1'b1
    } state_e;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v);
        return ~v + 64'd1;
    endfunction

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        is_div_q, is_div_d;
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
    logic        div0_q, div0_d;
    logic [31:0] opnd_q, opnd_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic        dbz_q, dbz_d;

    logic        a_neg_s, b_neg_s;
    logic [31:0] mag_a_s, mag_b_s;
    logic [32:0] mul_sum_s;
    logic [63:0] mul_next_s;
    logic [32:0] div_shift_s;
    logic [32:0] div_diff_s;
    logic        div_ge_s;
    logic [63:0] div_next_s;
    logic [63:0] prod_s;

    // Operand conditioning: magnitudes for signed ops, raw values for unsigned ops.
    assign a_neg_s = bus.Op[0] & bus.A[31];
    assign b_neg_s = bus.Op[0] & bus.B[31];
    assign mag_a_s = a_neg_s ? neg32(bus.A) : bus.A;
    assign mag_b_s = b_neg_s ? neg32(bus.B) : bus.B;

    // Multiply: low half of acc holds the multiplier and is shifted out as the product grows.
    assign mul_sum_s  = {1'b0, acc_q[63:32]} + ({1'b0, opnd_q} & {33{acc_q[0]}});
    assign mul_next_s = {mul_sum_s, acc_q[31:1]};

    // Divide: acc is {remainder, dividend/quotient}. The remainder stays below the divisor,
    // so bit 32 of the trial difference is a valid borrow flag.
    assign div_shift_s = {acc_q[63:32], acc_q[31]};
    assign div_diff_s  = div_shift_s - {1'b0, opnd_q};
    assign div_ge_s    = ~div_diff_s[32];
    assign div_next_s  = {(div_ge_s ? div_diff_s[31:0] : div_shift_s[31:0]), acc_q[30:0], div_ge_s};

    assign prod_s = neg_res_q ? neg64(acc_q) : acc_q;

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.Start && !bus.Flush) begin
                    state_d   = S_CALC;
                    cnt_d     = 6'd0;
                    is_div_d  = bus.Op[1];
                    neg_res_d = a_neg_s ^ b_neg_s;
                    neg_rem_d = a_neg_s;
                    div0_d    = bus.Op[1] & (bus.B == 32'd0);
                    if (bus.Op[1]) begin
                        opnd_d = mag_b_s;
                        acc_d  = {32'd0, mag_a_s};
                    end else begin
                        opnd_d = mag_a_s;
                        acc_d  = {32'd0, mag_b_s};
                    end
                end else if (!bus.Start) begin
                    if (bus.HiWe) begin
                        hi_d = bus.WData;
                    end else begin
                        hi_d = hi_q;
                    end
                    if (bus.LoWe) begin
                        lo_d = bus.WData;
                    end else begin
                        lo_d = lo_q;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                if (bus.Flush) begin
                    state_d = S_IDLE;
                    cnt_d   = 6'd0;
                end else if (cnt_q != 6'd32) begin
                    cnt_d = cnt_q + 6'd1;
                    if (is_div_q) begin
                        acc_d = div_next_s;
                    end else begin
                        acc_d = mul_next_s;
                    end
                end else begin
                    state_d = S_IDLE;
                    cnt_d   = 6'd0;
                    done_d  = 1'b1;
                    dbz_d   = div0_q;
                    if (is_div_q) begin
                        hi_d = neg_rem_q ? neg32(acc_q[63:32]) : acc_q[63:32];
                        if (div0_q) begin
                            lo_d = 32'hFFFF_FFFF;
                        end else begin
                            lo_d = neg_res_q ? neg32(acc_q[31:0]) : acc_q[31:0];
                        end
                    end else begin
                        hi_d = prod_s[63:32];
                        lo_d = prod_s[31:0];
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 6'd0;
            end
        endcase
    end

    // State and result registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 6'd0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            opnd_q    <= 32'd0;
            acc_q     <= 64'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign bus.Busy      = (state_q == S_CALC);
    assign bus.Done      = done_q;
    assign bus.DivByZero = dbz_q;
    assign bus.Hi        = hi_q;
    assign bus.Lo        = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed plus randomized check of ex_muldiv_unit against a plain-arithmetic HI/LO model.
module tb_ex_muldiv_unit;

    logic Clk;
    logic Rst_n;
    ex_muldiv_unit_if bus ();

    ex_muldiv_unit dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int tests;
    int fails;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Returns {div_by_zero, hi, lo} from ordinary 64-bit arithmetic.
    function automatic logic [64:0] ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        logic [63:0] ua, ub;
        ua = {32'd0, a};
        ub = {32'd0, b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: begin
                p = ua * ub;
                return {1'b0, p};
            end
            2'b01: begin
                q = sa * sb;
                return {1'b0, 64'(q)};
            end
            default: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                if (op == 2'b10) begin
                    p = {ua % ub, 32'd0} | (ua / ub);
                    return {1'b0, p};
                end
                q = sa / sb;
                r = sa % sb;
                return {1'b0, 32'(r), 32'(q)};
            end
        endcase
    endfunction

    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit wr_start, input bit noise);
        logic [64:0] r;
        int n;
        r = ref_op(op, a, b);
        bus.Start = 1'b1; bus.Op = op; bus.A = a; bus.B = b;
        bus.HiWe = wr_start; bus.LoWe = wr_start; bus.WData = 32'hDEAD_BEEF;
        @(posedge Clk); #1;
        bus.Start = 1'b0; bus.HiWe = 1'b0; bus.LoWe = 1'b0;
        bus.A = ~a; bus.B = ~b;
        check("busy_e0", {31'd0, bus.Busy}, 32'd1);
        check("done_e0", {31'd0, bus.Done}, 32'd0);
        check("hi_hold_e0", bus.Hi, exp_hi);
        check("lo_hold_e0", bus.Lo, exp_lo);
        n = 0;
        while (bus.Busy === 1'b1 && n < 100) begin
            n++;
            if (noise && n == 5) begin
                bus.Start = 1'b1; bus.Op = ~op; bus.A = a + 32'd1;
                bus.HiWe = 1'b1; bus.LoWe = 1'b1; bus.WData = 32'hBAD0_BAD0;
            end else begin
                bus.Start = 1'b0; bus.HiWe = 1'b0; bus.LoWe = 1'b0;
            end
            if (n == 16) check("hi_hold_mid", bus.Hi, exp_hi);
            @(posedge Clk); #1;
        end
        bus.Start = 1'b0; bus.HiWe = 1'b0; bus.LoWe = 1'b0;
        check("busy_cycles", 32'(n), 32'd33);
        check("done_pulse", {31'd0, bus.Done}, 32'd1);
        check("dbz", {31'd0, bus.DivByZero}, {31'd0, r[64]});
        check("hi", bus.Hi, r[63:32]);
        check("lo", bus.Lo, r[31:0]);
        exp_hi = r[63:32];
        exp_lo = r[31:0];
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        tests = 0; fails = 0;
        exp_hi = 32'd0; exp_lo = 32'd0;
        Rst_n = 1'b0;
        bus.Start = 1'b0; bus.Op = 2'b00; bus.A = 32'd0; bus.B = 32'd0;
        bus.Flush = 1'b0; bus.HiWe = 1'b0; bus.LoWe = 1'b0; bus.WData = 32'd0;
        #3;
        check("rst_busy", {31'd0, bus.Busy}, 32'd0);
        check("rst_done", {31'd0, bus.Done}, 32'd0);
        check("rst_dbz", {31'd0, bus.DivByZero}, 32'd0);
        check("rst_hi", bus.Hi, 32'd0);
        check("rst_lo", bus.Lo, 32'd0);
        @(posedge Clk); #1;
        Rst_n = 1'b1;
        @(posedge Clk); #1;

        // Directed operations, issued back-to-back on the Done cycle.
        do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_op(2'b01, 32'hFFFF_FFF9, 32'd6, 1'b0, 1'b0);
        do_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        do_op(2'b10, 32'd100, 32'd0, 1'b0, 1'b0);
        do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_op(2'b11, 32'hFFFF_FFF9, 32'd0, 1'b0, 1'b0);
        @(posedge Clk); #1;
        check("done_one_cycle", {31'd0, bus.Done}, 32'd0);
        check("dbz_one_cycle", {31'd0, bus.DivByZero}, 32'd0);

        // Flush of an in-flight divide.
        bus.Start = 1'b1; bus.Op = 2'b10; bus.A = 32'd1000; bus.B = 32'd7;
        @(posedge Clk); #1;
        bus.Start = 1'b0;
        repeat (9) begin @(posedge Clk); #1; end
        bus.Flush = 1'b1;
        @(posedge Clk); #1;
        bus.Flush = 1'b0;
        check("flush_busy", {31'd0, bus.Busy}, 32'd0);
        check("flush_done", {31'd0, bus.Done}, 32'd0);
        check("flush_hi", bus.Hi, exp_hi);
        check("flush_lo", bus.Lo, exp_lo);
        @(posedge Clk); #1;
        check("flush_no_done", {31'd0, bus.Done}, 32'd0);

        // Flush in IDLE suppresses Start.
        bus.Start = 1'b1; bus.Flush = 1'b1;
        @(posedge Clk); #1;
        bus.Start = 1'b0; bus.Flush = 1'b0;
        check("idle_flush_busy", {31'd0, bus.Busy}, 32'd0);

        // MTHI / MTLO in IDLE.
        bus.HiWe = 1'b1; bus.WData = 32'h1234_5678;
        @(posedge Clk); #1;
        bus.HiWe = 1'b0;
        check("mthi", bus.Hi, 32'h1234_5678);
        check("mthi_lo_kept", bus.Lo, exp_lo);
        exp_hi = 32'h1234_5678;
        bus.HiWe = 1'b1; bus.LoWe = 1'b1; bus.WData = 32'hCAFE_F00D;
        @(posedge Clk); #1;
        bus.HiWe = 1'b0; bus.LoWe = 1'b0;
        check("mthi_both", bus.Hi, 32'hCAFE_F00D);
        check("mtlo_both", bus.Lo, 32'hCAFE_F00D);
        exp_hi = 32'hCAFE_F00D; exp_lo = 32'hCAFE_F00D;

        // Write with Start is dropped; Start/HiWe/LoWe during Busy are ignored.
        do_op(2'b01, 32'd12345, 32'hFFFF_FF00, 1'b1, 1'b1);
        do_op(2'b10, 32'hFFFF_0000, 32'd3, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a calculation.
        bus.Start = 1'b1; bus.Op = 2'b00; bus.A = 32'd77; bus.B = 32'd99;
        @(posedge Clk); #1;
        bus.Start = 1'b0;
        repeat (19) begin @(posedge Clk); #1; end
        #2;
        Rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, bus.Busy}, 32'd0);
        check("arst_done", {31'd0, bus.Done}, 32'd0);
        check("arst_hi", bus.Hi, 32'd0);
        check("arst_lo", bus.Lo, 32'd0);
        exp_hi = 32'd0; exp_lo = 32'd0;
        @(posedge Clk); #1;
        check("arst_no_done", {31'd0, bus.Done}, 32'd0);
        Rst_n = 1'b1;
        @(posedge Clk); #1;
        do_op(2'b00, 32'd3, 32'd5, 1'b0, 1'b0);
        do_op(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);

        // Randomized operations.
        for (int i = 0; i < 24; i++) begin
            do_op(2'($urandom_range(0, 3)), rand_val(), rand_val(), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
